// File: rtl/vfpu_result_writeback.sv
// vfpu_result_writeback: buffers VFPU results and stores them to TCDM.
// Define VFPU_WB_ALIGN_CHECK_EN to reject misaligned base/stride at start.
module vfpu_result_writeback #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [31:0]             base_addr_i,
   input  logic [31:0]             stride_i,
   input  logic [LEN_WIDTH-1:0]    length_i,
   input  logic                    result_valid_i,
   output logic                    result_ready_o,
   input  logic [DATA_WIDTH-1:0]   result_data_i,
   input  logic [DATA_WIDTH/8-1:0] result_strb_i,
   output logic                    tcdm_req_o,
   input  logic                    tcdm_gnt_i,
   output logic [31:0]             tcdm_add_o,
   output logic                    tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
   output logic [DATA_WIDTH-1:0]   tcdm_data_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [LEN_WIDTH-1:0]    words_left_o
);

   localparam int unsigned BW = DATA_WIDTH / 8;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PONE = 1;
   localparam logic [LEN_WIDTH-1:0] LONE = 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          stride_q, stride_d;
   logic [LEN_WIDTH-1:0] left_q, left_d;
   logic [LEN_WIDTH-1:0] acc_q, acc_d;
   logic [AW:0]          wptr_q, wptr_d;
   logic [AW:0]          rptr_q, rptr_d;
   logic                 err_q, err_d;

   logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [BW-1:0]         strb_mem [FIFO_DEPTH];

   logic run, full, empty, push, pop, misal;

`ifdef VFPU_WB_ALIGN_CHECK_EN
   assign misal = (base_addr_i[1:0] != 2'b00)
               || (stride_i[1:0] != 2'b00);
`else
   assign misal = 1'b0;
`endif

   assign run   = (state_q == RUN);
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW])
               && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign result_ready_o = run && !full && (acc_q != '0);
   assign push           = result_valid_i && result_ready_o;
   assign tcdm_req_o     = run && !empty;
   assign pop            = tcdm_req_o && tcdm_gnt_i;

   assign tcdm_add_o  = addr_q;
   assign tcdm_wen_o  = !tcdm_req_o;
   assign tcdm_be_o   = tcdm_req_o ? strb_mem[rptr_q[AW-1:0]] : '0;
   assign tcdm_data_o = tcdm_req_o ? data_mem[rptr_q[AW-1:0]] : '0;

   assign busy_o       = run;
   assign done_o       = (state_q == DONE);
   assign err_o        = err_q;
   assign words_left_o = left_q;

   // Next-state: job setup, FIFO pointers, address walk, clear override.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      left_d   = left_q;
      acc_d    = acc_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      err_d    = 1'b0;
      if (push) begin
         wptr_d = wptr_q + PONE;
         acc_d  = acc_q - LONE;
      end
      if (pop) begin
         rptr_d = rptr_q + PONE;
         addr_d = addr_q + stride_q;
         left_d = left_q - LONE;
      end
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (misal) begin
                  err_d = 1'b1;
               end else if (length_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d  = RUN;
                  addr_d   = base_addr_i;
                  stride_d = stride_i;
                  left_d   = length_i;
                  acc_d    = length_i;
               end
            end
         end
         RUN: begin
            if (pop && (left_q == LONE)) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         wptr_d  = '0;
         rptr_d  = '0;
         left_d  = '0;
         acc_d   = '0;
         err_d   = 1'b0;
      end
   end

   // State, counters and pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         left_q   <= '0;
         acc_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         left_q   <= left_d;
         acc_q    <= acc_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         err_q    <= err_d;
      end
   end

   // Result storage; contents are masked by tcdm_req_o, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem[wptr_q[AW-1:0]] <= result_data_i;
         strb_mem[wptr_q[AW-1:0]] <= result_strb_i;
      end
   end

endmodule

// File: tb/tb_vfpu_result_writeback.sv
// tb_vfpu_result_writeback: scoreboard bench for the VFPU writeback.
// Expected stores are queued at job start and popped on each grant.
module tb_vfpu_result_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_i;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [31:0] stride_i;
   logic [15:0] length_i;
   logic        result_valid_i;
   logic        result_ready_o;
   logic [31:0] result_data_i;
   logic [3:0]  result_strb_i;
   logic        tcdm_req_o;
   logic        tcdm_gnt_i;
   logic [31:0] tcdm_add_o;
   logic        tcdm_wen_o;
   logic [3:0]  tcdm_be_o;
   logic [31:0] tcdm_data_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [15:0] words_left_o;

   vfpu_result_writeback dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear_i),
      .start_i        (start_i),
      .base_addr_i    (base_addr_i),
      .stride_i       (stride_i),
      .length_i       (length_i),
      .result_valid_i (result_valid_i),
      .result_ready_o (result_ready_o),
      .result_data_i  (result_data_i),
      .result_strb_i  (result_strb_i),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .err_o          (err_o),
      .words_left_o   (words_left_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_mis = 0;
   int cyc = 0;
   int gcnt = 0;
   int reqc = 0;
   int rdyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_gnt_cyc = 0;
   int start_cyc = 0;
   int job_d0 = 0;

   int          s_idx = 0;
   int          s_cnt = 0;
   bit          s_en = 0;
   logic [31:0] s_seed = '0;
   bit          acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int k);
      return s_seed + 32'(k);
   endfunction

   function automatic logic [3:0] strb_of(input int k);
      return 4'hF ^ 4'(k);
   endfunction

   // Result stream driver: advance after each accepted beat.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (acc) s_idx++;
         result_valid_i = s_en && (s_idx < s_cnt);
         result_data_i  = word_of(s_idx);
         result_strb_i  = strb_of(s_idx);
         @(negedge clk);
         acc = result_valid_i && result_ready_o;
      end
   end

   // Store monitor: scoreboard, hold-while-stalled and counters.
   initial begin
      bit          stall = 0;
      logic [31:0] h_add = '0;
      logic [31:0] h_dat = '0;
      logic [3:0]  h_be = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (stall) begin
            chk("hold_req", 64'(tcdm_req_o), 64'd1);
            chk("hold_add", 64'(tcdm_add_o), 64'(h_add));
            chk("hold_data", 64'(tcdm_data_o), 64'(h_dat));
            chk("hold_be", 64'(tcdm_be_o), 64'(h_be));
         end
         if (tcdm_req_o) begin
            reqc++;
            chk("wen", 64'(tcdm_wen_o), 64'd0);
         end
         if (result_ready_o) rdyc++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (tcdm_req_o && tcdm_gnt_i) begin
            gcnt++;
            last_gnt_cyc = cyc;
            chk("sb_has", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("st_add", 64'(tcdm_add_o), 64'(e.a));
               chk("st_data", 64'(tcdm_data_o), 64'(e.d));
               chk("st_be", 64'(tcdm_be_o), 64'(e.b));
            end
         end
         stall = tcdm_req_o && !tcdm_gnt_i && !clear_i;
         h_add = tcdm_add_o;
         h_dat = tcdm_data_o;
         h_be  = tcdm_be_o;
      end
   end

   task automatic setup_stream(input logic [31:0] seed,
                               input int n);
      s_en = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      s_idx  = 0;
      s_cnt  = n;
      s_seed = seed;
      s_en   = 1;
   endtask

   task automatic pulse_start(input logic [31:0] b,
                              input logic [31:0] s,
                              input int l);
      @(posedge clk);
      #1;
      job_d0      = done_cnt;
      start_cyc   = cyc;
      start_i     = 1'b1;
      base_addr_i = b;
      stride_i    = s;
      length_i    = 16'(l);
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] b,
                            input logic [31:0] s,
                            input int l);
      exp_t e;
      for (int k = 0; k < l; k++) begin
         e.a = b + s * 32'(k);
         e.d = word_of(k);
         e.b = strb_of(k);
         sb.push_back(e);
      end
      pulse_start(b, s, l);
   endtask

   task automatic wait_job(input int l);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != job_d0) begin
            ok = 1;
            break;
         end
      end
      chk("job_timeout", 64'(ok), 64'd1);
      chk("done_cnt", 64'(done_cnt), 64'(job_d0 + 1));
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("wl_end", 64'(words_left_o), 64'd0);
      if (l != 0)
         chk("done_lat", 64'(done_cyc), 64'(last_gnt_cyc + 1));
   endtask

   initial begin
      int g0, r0, y0, d0;
      rst_n       = 1'b0;
      clear_i     = 1'b0;
      start_i     = 1'b0;
      base_addr_i = '0;
      stride_i    = '0;
      length_i    = '0;
      tcdm_gnt_i  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(result_ready_o), 64'd0);
      chk("rst_req", 64'(tcdm_req_o), 64'd0);
      chk("rst_add", 64'(tcdm_add_o), 64'd0);
      chk("rst_wen", 64'(tcdm_wen_o), 64'd1);
      chk("rst_be", 64'(tcdm_be_o), 64'd0);
      chk("rst_data", 64'(tcdm_data_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_wl", 64'(words_left_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic job, grant always high
      tcdm_gnt_i = 1'b1;
      setup_stream(32'hA, 4);
      start_job(32'h1000, 32'd4, 4);
      @(negedge clk);
      chk("start_busy", 64'(busy_o), 64'd1);
      chk("start_ready", 64'(result_ready_o), 64'd1);
      chk("start_wl", 64'(words_left_o), 64'd4);
      wait_job(4);
      chk("basic_rate", 64'(last_gnt_cyc - start_cyc), 64'd5);

      // backpressure: no grants for 10 cycles
      tcdm_gnt_i = 1'b0;
      setup_stream(32'h100, 8);
      start_job(32'h2000, 32'd8, 8);
      repeat (10) @(posedge clk);
      #2;
      chk("bp_accepts", 64'(s_idx), 64'd4);
      chk("bp_ready", 64'(result_ready_o), 64'd0);
      tcdm_gnt_i = 1'b1;
      wait_job(8);

      // address wrap and a surplus beat
      setup_stream(32'h200, 4);
      start_job(32'hFFFF_FFF8, 32'd4, 3);
      wait_job(3);
      chk("surplus_acc", 64'(s_idx), 64'd3);
      chk("surplus_vld", 64'(result_valid_i), 64'd1);

      // zero length
      setup_stream(32'h300, 2);
      r0 = reqc;
      y0 = rdyc;
      start_job(32'h3000, 32'd4, 0);
      repeat (4) @(posedge clk);
      #2;
      chk("z_done_cnt", 64'(done_cnt), 64'(job_d0 + 1));
      chk("z_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
      chk("z_req", 64'(reqc), 64'(r0));
      chk("z_ready", 64'(rdyc), 64'(y0));
      chk("z_acc", 64'(s_idx), 64'd0);

      // clear after two of six grants
      setup_stream(32'h600, 6);
      g0 = gcnt;
      start_job(32'h5000, 32'd4, 6);
      for (int i = 0; i < 100; i++) begin
         if (gcnt - g0 >= 2) break;
         @(posedge clk);
         #1;
      end
      chk("clr_grants", 64'(gcnt - g0), 64'd2);
      d0 = done_cnt;
      clear_i    = 1'b1;
      tcdm_gnt_i = 1'b0;
      @(posedge clk);
      #1;
      clear_i = 1'b0;
      @(negedge clk);
      chk("clr_req", 64'(tcdm_req_o), 64'd0);
      chk("clr_wl", 64'(words_left_o), 64'd0);
      chk("clr_busy", 64'(busy_o), 64'd0);
      chk("clr_ready", 64'(result_ready_o), 64'd0);
      sb.delete();
      s_en = 0;
      repeat (4) @(posedge clk);
      #2;
      chk("clr_nodone", 64'(done_cnt), 64'(d0));
      tcdm_gnt_i = 1'b1;
      setup_stream(32'h700, 3);
      start_job(32'h4000, 32'd8, 3);
      wait_job(3);

      // misaligned base
`ifdef VFPU_WB_ALIGN_CHECK_EN
      setup_stream(32'h900, 2);
      r0 = reqc;
      pulse_start(32'h1002, 32'd4, 2);
      @(negedge clk);
      chk("al_err", 64'(err_o), 64'd1);
      chk("al_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      chk("al_err_off", 64'(err_o), 64'd0);
      repeat (4) @(posedge clk);
      #2;
      chk("al_req", 64'(reqc), 64'(r0));
      chk("al_done", 64'(done_cnt), 64'(job_d0));
`else
      setup_stream(32'h900, 2);
      start_job(32'h1002, 32'd4, 2);
      @(negedge clk);
      chk("al_err", 64'(err_o), 64'd0);
      wait_job(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/vfpu_result_writeback.md
# vfpu_result_writeback

Write-back stage directly downstream of the VFPU datapath. It consumes the VFPU result stream, buffers it in a small FIFO, and issues word-granular TCDM store requests at `base + k*stride`. It emits a completion pulse once `length` words have been granted. The control unit drives its job registers and consumes its flags.

## Interface
- `DATA_WIDTH`, 32: result and TCDM data width; multiple of 8.
- `FIFO_DEPTH`, 4: result buffer entries; power of 2, ≥2.
- `LEN_WIDTH`, 16: width of the job length counter.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active low.
- `clear_i`  in  1  synchronous soft clear.
- `start_i`  in  1  job start pulse; sampled in IDLE only.
- `base_addr_i`  in  32  first store address.
- `stride_i`  in  32  address increment per word.
- `length_i`  in  LEN_WIDTH  number of words in the job.
- `result_valid_i`  in  1  result stream valid.
- `result_ready_o`  out  1  result stream ready.
- `result_data_i`  in  DATA_WIDTH  result word.
- `result_strb_i`  in  DATA_WIDTH/8  byte strobes.
- `tcdm_req_o`  out  1  store request.
- `tcdm_gnt_i`  in  1  store grant.
- `tcdm_add_o`  out  32  store address.
- `tcdm_wen_o`  out  1  write enable, active low; 0 = write.
- `tcdm_be_o`  out  DATA_WIDTH/8  byte enables (from strobes).
- `tcdm_data_o`  out  DATA_WIDTH  store data.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  alignment error pulse (see Configuration).
- `words_left_o`  out  LEN_WIDTH  words not yet granted.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start_i` with `length_i` ≠ 0. Latches `base_addr_i` into the address register, `stride_i` into the stride register, `length_i` into `words_left` and into `to_accept`.
- IDLE → DONE on `start_i` with `length_i` = 0. No stream beats or requests occur.
- RUN → DONE in the cycle after the grant that takes `words_left` to 0.
- DONE → IDLE unconditionally after one cycle. `done_o` = 1 only in DONE.
- `start_i` outside IDLE is ignored.
- Push into the FIFO when `result_valid_i && result_ready_o`; `to_accept` decrements on each push.
- `result_ready_o` = RUN && !fifo_full && `to_accept` ≠ 0. Surplus beats beyond `length` are never accepted.
- `tcdm_req_o` = RUN && !fifo_empty. Address, data and be come from the FIFO head and the address register.
- `tcdm_wen_o` = 0 whenever `tcdm_req_o` = 1, otherwise 1.
- On `tcdm_req_o && tcdm_gnt_i`: pop the head, advance the address register by `stride` modulo 2^32 (wrap, no saturation), decrement `words_left`.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- `clear_i` has priority over everything and returns to IDLE in the next cycle. It flushes the FIFO, zeroes `words_left`/`to_accept`, and produces no `done_o`.
- Reset values: `result_ready_o`=0, `tcdm_req_o`=0, `tcdm_add_o`=0, `tcdm_wen_o`=1, `tcdm_be_o`=0, `tcdm_data_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `words_left_o`=0. FSM state is IDLE.

## Timing
- Start latency: `start_i` in cycle N makes `busy_o`/`result_ready_o` high in N+1.
- No FIFO bypass: a beat accepted in cycle N is presented on TCDM no earlier than N+1.
- Sustained throughput: 1 word/cycle with `tcdm_gnt_i` held high and a continuously valid stream.
- Request stability: while `tcdm_req_o`=1 and `tcdm_gnt_i`=0, `tcdm_add_o`, `tcdm_data_o` and `tcdm_be_o` hold stable.
- Request retirement: `tcdm_req_o` is never withdrawn before grant, except by `clear_i` or reset.
- Done timing: `done_o` rises exactly one cycle after the final grant.
- `words_left_o` is registered and reflects grants of the previous cycle.

## Configuration
- `VFPU_WB_ALIGN_CHECK_EN` defined: a start with `base_addr_i[1:0]` ≠ 0 or `stride_i[1:0]` ≠ 0 is rejected. The FSM stays in IDLE, `err_o` pulses for one cycle (N+1), and there is no `done_o`.
- `VFPU_WB_ALIGN_CHECK_EN` not defined: no check is performed, `err_o` is tied to 0, and misaligned addresses are issued as given.

## Test plan
- Basic job: base 0x1000, stride 4, length 4, stream 0xA..0xD, gnt held 1 → stores at 0x1000/4/8/C in consecutive cycles, `done_o` one cycle after the 4th grant.
- Backpressure: gnt 0 for 10 cycles, FIFO_DEPTH 4, stream always valid → `result_ready_o` drops after 4 accepts; `tcdm_add_o`/`tcdm_data_o` stable throughout; all 8 words of an 8-word job stored in order.
- Address wrap and surplus: base 0xFFFF_FFF8, stride 4, length 3 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; a 4th valid beat is not accepted.
- Zero length: start with length 0 → `done_o` in N+1, `tcdm_req_o` never asserted, `result_ready_o` stays 0.
- Clear mid-job: `clear_i` after 2 of 6 grants → IDLE next cycle, `tcdm_req_o`=0, `words_left_o`=0, no `done_o`; a subsequent job runs correctly from an empty FIFO.
- With `VFPU_WB_ALIGN_CHECK_EN`: base 0x1002 → `err_o` pulse, FSM stays IDLE, no requests. Without the macro: the same stimulus stores at 0x1002.
